jtpopeye_txt: RTL and testbench

JTPOPEYE_TXT -- requirements
Module: jtpopeye_txt

---
 rtl/jtpopeye_txt.sv | 103 ++++++++++
 tb/tb_jtpopeye_txt.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtpopeye_txt.sv
// Text layer: 32x32 tile map in dual-port RAM, 8x8 1bpp character ROM fetch, per-pixel shifter.
// Pixel X is registered on the pxl_cen tick that samples H=X; CPU reads take 1 clk; never stalls or backpressures.

module jtpopeye_txt (
  input  logic        rst_n,
  input  logic        clk,
  input  logic        pxl_cen,
  input  logic [8:0]  H,
  input  logic [7:0]  V,
  input  logic        VB_n,
  input  logic [10:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_we,
  output logic [7:0]  cpu_dout,
  output logic [10:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic [3:0]  txtc,
  output logic        txtv
);

  // Logically one 2048x8 RAM; split by address bit 10 so one video read returns code and colour together.
  logic [7:0] code_mem [0:1023];
  logic [7:0] attr_mem [0:1023];

  logic [2:0] ph;
  logic [4:0] fetch_col;
  logic [9:0] fetch_idx;
  logic [7:0] ram_code;
  logic [3:0] ram_col;
  logic [7:0] code_r;
  logic [3:0] col_r;
  logic [7:0] preload;
  logic [7:0] shift;
  logic [3:0] colour;
  logic [3:0] warm;
  logic       pix;
  logic       vis;

  assign ph        = H[2:0];
  assign fetch_col = H[7:3] + 5'd1;
  assign fetch_idx = {V[7:3], fetch_col};
  assign pix       = shift[7];
  assign vis       = ~H[8] & VB_n & warm[3];

  always_ff @(posedge clk) begin
    if (cpu_we && !cpu_addr[10]) code_mem[cpu_addr[9:0]] <= cpu_din;
    if (cpu_we &&  cpu_addr[10]) attr_mem[cpu_addr[9:0]] <= cpu_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_dout <= 8'd0;
    end else begin
      cpu_dout <= cpu_addr[10] ? attr_mem[cpu_addr[9:0]] : code_mem[cpu_addr[9:0]];
    end
  end

  // Video read port samples on the phase-1 tick; a CPU write in that same clk lands after the read.
  always_ff @(posedge clk) begin
    if (pxl_cen && ph == 3'd1) begin
      ram_code <= code_mem[fetch_idx];
      ram_col  <= attr_mem[fetch_idx][3:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_r   <= 8'd0;
      col_r    <= 4'd0;
      rom_addr <= 11'd0;
      preload  <= 8'd0;
      shift    <= 8'd0;
      colour   <= 4'd0;
      warm     <= 4'd0;
    end else if (pxl_cen) begin
      if (ph == 3'd2) begin
        code_r <= ram_code;
        col_r  <= ram_col;
      end
      if (ph == 3'd3) rom_addr <= {code_r, V[2:0]};
      if (ph == 3'd6) preload <= rom_data;
      if (ph == 3'd7) begin
        shift  <= preload;
        colour <= col_r;
      end else begin
        shift  <= {shift[6:0], 1'b0};
      end
      // Outputs stay transparent until a full tile period has elapsed since reset.
      if (!warm[3]) warm <= warm + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txtv <= 1'b1;
      txtc <= 4'd0;
    end else if (pxl_cen) begin
      txtv <= ~(pix & vis);
      txtc <= (pix & vis) ? colour : 4'd0;
    end
  end

endmodule

// File: tb/tb_jtpopeye_txt.sv
// Self-checking bench for jtpopeye_txt: directed steps with random RAM/ROM contents against a tile-map reference model.

module tb_jtpopeye_txt;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pxl_cen = 1'b0;
  logic [8:0]  H = 9'd0;
  logic [7:0]  V = 8'd0;
  logic        VB_n = 1'b1;
  logic [10:0] cpu_addr = 11'd0;
  logic [7:0]  cpu_din = 8'd0;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_dout;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic [3:0]  txtc;
  logic        txtv;

  logic [7:0]  rom_mem [0:2047];
  logic [7:0]  ram_sh  [0:2047];

  int n_assert = 0;
  int n_fail   = 0;

  // mode 1: single-tile pattern check on H=0..7; mode 2: all-ones ROM, txtv follows blanking only
  int          mode = 0;
  logic        chk_rom = 1'b0;
  logic        coll_en = 1'b0;
  logic [8:0]  coll_h = 9'd0;
  logic [10:0] coll_addr = 11'd0;
  logic [7:0]  coll_din = 8'd0;
  logic [7:0]  pat = 8'b0011_1100;

  jtpopeye_txt dut (
    .rst_n    (rst_n),
    .clk      (clk),
    .pxl_cen  (pxl_cen),
    .H        (H),
    .V        (V),
    .VB_n     (VB_n),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_din),
    .cpu_we   (cpu_we),
    .cpu_dout (cpu_dout),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .txtc     (txtc),
    .txtv     (txtv)
  );

  always #5 clk = ~clk;

  assign rom_data = rom_mem[rom_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Screen pixel (h, v) straight from the tile-map definition.
  function automatic void model(input logic [8:0] h, input logic [7:0] v, input logic vb,
                                output logic ev, output logic [3:0] ec);
    logic [9:0] idx;
    logic [7:0] code;
    logic [7:0] row;
    logic [7:0] attr;
    logic       bitv;
    idx  = {v[7:3], h[7:3]};
    code = ram_sh[{1'b0, idx}];
    attr = ram_sh[{1'b1, idx}];
    row  = rom_mem[{code, v[2:0]}];
    bitv = row[3'd7 - h[2:0]];
    if (h[8] || !vb) bitv = 1'b0;
    ev = ~bitv;
    ec = bitv ? attr[3:0] : 4'd0;
  endfunction

  task automatic wr(input logic [10:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_addr = a;
    cpu_din  = d;
    cpu_we   = 1'b1;
    @(negedge clk);
    cpu_we   = 1'b0;
    ram_sh[a] = d;
  endtask

  task automatic fill_ram();
    for (int i = 0; i < 2048; i++) begin
      @(negedge clk);
      cpu_addr = i[10:0];
      cpu_din  = 8'($urandom);
      cpu_we   = 1'b1;
      ram_sh[i] = cpu_din;
    end
    @(negedge clk);
    cpu_we = 1'b0;
  endtask

  task automatic step(input logic [8:0] h);
    logic       ev;
    logic [3:0] ec;
    logic       pb;
    @(negedge clk);
    H       = h;
    pxl_cen = 1'b1;
    if (coll_en && h == coll_h) begin
      cpu_addr = coll_addr;
      cpu_din  = coll_din;
      cpu_we   = 1'b1;
    end
    @(negedge clk);
    pxl_cen = 1'b0;
    cpu_we  = 1'b0;
    model(h, V, VB_n, ev, ec);
    check("txtv", {31'd0, txtv}, {31'd0, ev});
    check("txtc", {28'd0, txtc}, {28'd0, ec});
    if (mode == 1 && !h[8] && h[7:3] == 5'd0) begin
      pb = pat[3'd7 - h[2:0]];
      check("tile0_txtv", {31'd0, txtv}, {31'd0, pb});
      check("tile0_txtc", {28'd0, txtc}, pb ? 32'd0 : 32'd7);
    end
    if (mode == 2) check("blank_txtv", {31'd0, txtv}, {31'd0, h[8] | ~VB_n});
    if (chk_rom && h >= 9'h1FB) check("rom_addr", {21'd0, rom_addr}, 32'h090);
  endtask

  task automatic line();
    for (int h = 9'h1E0; h <= 9'h1FF; h++) step(h[8:0]);
    for (int h = 0; h < 256; h++) step(h[8:0]);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      rom_mem[i] = 8'($urandom);
      ram_sh[i]  = 8'd0;
    end

    // Reset held with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      H        = 9'($urandom);
      V        = 8'($urandom);
      VB_n     = 1'($urandom);
      pxl_cen  = 1'($urandom);
      cpu_addr = 11'($urandom);
      cpu_din  = 8'($urandom);
      @(posedge clk);
      #1;
      check("rst_txtv", {31'd0, txtv}, 32'd1);
      check("rst_txtc", {28'd0, txtc}, 32'd0);
      check("rst_rom_addr", {21'd0, rom_addr}, 32'd0);
      check("rst_cpu_dout", {24'd0, cpu_dout}, 32'd0);
    end
    @(negedge clk);
    pxl_cen = 1'b0;
    VB_n    = 1'b1;
    rst_n   = 1'b1;

    // CPU port read-back
    wr(11'h000, 8'hA5);
    wr(11'h400, 8'h3C);
    @(negedge clk);
    cpu_addr = 11'h000;
    @(negedge clk);
    check("cpu_rd_code", {24'd0, cpu_dout}, 32'hA5);
    cpu_addr = 11'h400;
    @(negedge clk);
    check("cpu_rd_attr", {24'd0, cpu_dout}, 32'h3C);

    // Single tile on a random background
    fill_ram();
    wr(11'h000, 8'h12);
    wr(11'h400, 8'h07);
    rom_mem[11'h090] = 8'hC3;
    V = 8'd0;
    mode = 1;
    chk_rom = 1'b1;
    line();
    mode = 0;
    chk_rom = 1'b0;

    // Random lines
    for (int n = 0; n < 4; n++) begin
      V = 8'($urandom);
      line();
    end

    // Column wrap: non-blank tiles at columns 31 and 0
    V = 8'h2B;
    wr({1'b0, 5'd5, 5'd31}, 8'h81);
    wr({1'b0, 5'd5, 5'd0},  8'h7E);
    wr({1'b1, 5'd5, 5'd31}, 8'h0A);
    wr({1'b1, 5'd5, 5'd0},  8'h05);
    rom_mem[{8'h81, 3'd3}] = 8'hB5;
    rom_mem[{8'h7E, 3'd3}] = 8'h9D;
    line();

    // Code write colliding with the phase-1 fetch of tile 5, row 1
    V = 8'h08;
    wr(11'h025, 8'h12);
    wr(11'h425, 8'h05);
    rom_mem[{8'h12, 3'd0}] = 8'hC3;
    rom_mem[{8'h34, 3'd0}] = 8'h3C;
    coll_en   = 1'b1;
    coll_h    = 9'd33;
    coll_addr = 11'h025;
    coll_din  = 8'h34;
    line();
    coll_en = 1'b0;
    ram_sh[11'h025] = 8'h34;
    line();

    // Blanking with an all-ones ROM
    for (int i = 0; i < 2048; i++) rom_mem[i] = 8'hFF;
    mode = 2;
    VB_n = 1'b1;
    V = 8'($urandom);
    line();

    // Asynchronous reset mid-frame; RAM must survive it
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_txtv", {31'd0, txtv}, 32'd1);
    check("arst_txtc", {28'd0, txtc}, 32'd0);
    check("arst_rom_addr", {21'd0, rom_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cpu_addr = 11'h025;
    @(negedge clk);
    check("ram_kept", {24'd0, cpu_dout}, 32'h34);

    VB_n = 1'b0;
    line();
    VB_n = 1'b1;
    line();
    mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
